// File: rtl/axi_burst_mem_slave_pkg.sv
// Shared types and constants for the AXI-style burst memory slave.
// Burst/response encodings plus the per-channel FSM state types.
package axi_burst_mem_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts plus range check.
// An illegal WRAP length falls back to INCR and is flagged.
module axi_addr_gen
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int AW    = 8,
  parameter int LENW  = 4,
  parameter int DEPTH = 256
) (
  input  logic [AW-1:0]   addr,
  input  logic [LENW-1:0] len,
  input  logic [1:0]      burst,
  output logic [AW-1:0]   next_addr,
  output logic            in_range,
  output logic            wrap_bad
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic          legal;
  logic [AW-1:0] mask;
  logic [AW-1:0] inc;

  always_comb begin
    legal = (len == LENW'(1)) || (len == LENW'(3)) ||
            (len == LENW'(7)) || (len == LENW'(15));
    wrap_bad = (burst == BURST_WRAP) && !legal;
    mask = AW'(len);
    inc = addr + AW'(1);
    in_range = {1'b0, addr} < DEPTH_W;
    next_addr = inc;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if (burst == BURST_WRAP && legal) begin
      next_addr = (addr & ~mask) | (inc & mask);
    end
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// Burst memory slave: independent write (AW/W/B) and read (AR/R) FSMs.
// DEPTH must not exceed 2**AW.
module axi_burst_mem_slave
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int IDW   = 4,
  parameter int LENW  = 4,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [AW-1:0]   AWADDR,
  input  logic [LENW-1:0] AWLEN,
  input  logic [IDW-1:0]  AWID,
  input  logic [1:0]      AWBURST,
  input  logic            WVALID,
  output logic            WREADY,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WSTRB,
  input  logic            WLAST,
  output logic            BVALID,
  input  logic            BREADY,
  output logic [IDW-1:0]  BID,
  output logic [1:0]      BRESP,
  input  logic            ARVALID,
  output logic            ARREADY,
  input  logic [AW-1:0]   ARADDR,
  input  logic [LENW-1:0] ARLEN,
  input  logic [IDW-1:0]  ARID,
  input  logic [1:0]      ARBURST,
  output logic            RVALID,
  input  logic            RREADY,
  output logic [DW-1:0]   RDATA,
  output logic [IDW-1:0]  RID,
  output logic [1:0]      RRESP,
  output logic            RLAST
);

  localparam int NB = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  w_state_e        w_state, w_nxt;
  logic [AW-1:0]   w_addr;
  logic [LENW-1:0] w_len;
  logic [LENW-1:0] w_cnt;
  logic [IDW-1:0]  w_id;
  logic [1:0]      w_burst;
  logic            w_err;
  logic [AW-1:0]   w_next;
  logic            w_ok;
  logic            w_wbad;
  logic            w_beat;
  logic            w_end;

  axi_addr_gen #(.AW(AW), .LENW(LENW), .DEPTH(DEPTH)) u_wgen (
    .addr      (w_addr),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next),
    .in_range  (w_ok),
    .wrap_bad  (w_wbad)
  );

  assign AWREADY = (w_state == W_IDLE);
  assign WREADY  = (w_state == W_DATA);
  assign BVALID  = (w_state == W_RESP);
  assign BID     = w_id;
  assign BRESP   = BVALID ? resp_of(w_err | w_wbad) : RESP_OKAY;
  assign w_beat  = WREADY && WVALID;
  assign w_end   = (w_cnt == w_len);

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_nxt;
  end

  always_comb begin
    w_nxt = w_state;
    unique case (w_state)
      W_IDLE: if (AWVALID) w_nxt = W_DATA;
      W_DATA: if (w_beat && w_end) w_nxt = W_RESP;
      W_RESP: if (BREADY) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_id    <= '0;
      w_burst <= BURST_FIXED;
      w_err   <= 1'b0;
    end else if (AWREADY && AWVALID) begin
      w_addr  <= AWADDR;
      w_len   <= AWLEN;
      w_cnt   <= '0;
      w_id    <= AWID;
      w_burst <= AWBURST;
      w_err   <= 1'b0;
    end else if (w_beat) begin
      w_addr <= w_next;
      if (!w_end) w_cnt <= w_cnt + LENW'(1);
      w_err <= w_err | !w_ok | (WLAST != w_end);
    end
  end

  // Single write port; out-of-range beats and reset cycles never touch memory.
  always_ff @(posedge clk) begin
    if (!rst && w_beat && w_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (WSTRB[b]) mem[w_addr[IW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  r_state_e        r_state, r_nxt;
  logic [AW-1:0]   r_addr;
  logic [LENW-1:0] r_len;
  logic [LENW-1:0] r_cnt;
  logic [IDW-1:0]  r_id;
  logic [1:0]      r_burst;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_resp;
  logic            r_last;
  logic            r_idle;
  logic            r_hs;
  logic            r_done;
  logic [AW-1:0]   g_addr;
  logic [LENW-1:0] g_len;
  logic [1:0]      g_burst;
  logic [AW-1:0]   g_next;
  logic            g_ok;
  logic            g_wbad;
  logic [DW-1:0]   g_word;

  assign r_idle  = (r_state == R_IDLE);
  assign ARREADY = r_idle;
  assign RVALID  = (r_state == R_DATA);
  assign RDATA   = r_data;
  assign RRESP   = r_resp;
  assign RLAST   = r_last;
  assign RID     = r_id;
  assign r_hs    = RVALID && RREADY;
  assign r_done  = (r_cnt == r_len);

  // In idle the generator looks at the AR request so beat 0 loads at handshake.
  assign g_addr  = r_idle ? ARADDR  : r_addr;
  assign g_len   = r_idle ? ARLEN   : r_len;
  assign g_burst = r_idle ? ARBURST : r_burst;
  assign g_word  = g_ok ? mem[g_addr[IW-1:0]] : '0;

  axi_addr_gen #(.AW(AW), .LENW(LENW), .DEPTH(DEPTH)) u_rgen (
    .addr      (g_addr),
    .len       (g_len),
    .burst     (g_burst),
    .next_addr (g_next),
    .in_range  (g_ok),
    .wrap_bad  (g_wbad)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_nxt;
  end

  always_comb begin
    r_nxt = r_state;
    unique case (r_state)
      R_IDLE: if (ARVALID) r_nxt = R_DATA;
      R_DATA: if (r_hs && r_done) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_burst <= BURST_FIXED;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
      r_last  <= 1'b0;
    end else if (r_idle && ARVALID) begin
      r_addr  <= g_next;
      r_len   <= ARLEN;
      r_cnt   <= '0;
      r_id    <= ARID;
      r_burst <= ARBURST;
      r_data  <= g_word;
      r_resp  <= resp_of(!g_ok | g_wbad);
      r_last  <= (ARLEN == '0);
    end else if (r_hs && !r_done) begin
      r_addr <= g_next;
      r_cnt  <= r_cnt + LENW'(1);
      r_data <= g_word;
      r_resp <= resp_of(!g_ok | g_wbad);
      r_last <= ((r_cnt + LENW'(1)) == r_len);
    end else if (r_hs) begin
      r_last <= 1'b0;
    end
  end

endmodule
